// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - WIDTH-bit add/subtract sequenced over one shared 4-bit ripple slice
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ovf
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic             carry_reg, cout_reg, ovf_reg;
    logic [IW-1:0]    idx;
    logic             last_nib;
    logic [3:0]       a_nib, b_nib, s_nib;
    logic [4:0]       c;

    assign last_nib = (idx == IW'(NIB - 1));
    assign a_nib    = a_reg[{idx, 2'b00} +: 4];
    assign b_nib    = b_reg[{idx, 2'b00} +: 4];

    // Four full-adder cells; c[3] is the carry into the top bit of the nibble.
    assign c[0] = carry_reg;
    for (genvar j = 0; j < 4; j++) begin : g_fa
        assign s_nib[j] = a_nib[j] ^ b_nib[j] ^ c[j];
        assign c[j+1]   = (a_nib[j] & b_nib[j]) | (c[j] & (a_nib[j] ^ b_nib[j]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_nib) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_reg     <= req_a;
                        b_reg     <= req_sub ? ~req_b : req_b;
                        carry_reg <= req_sub;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    sum_reg[{idx, 2'b00} +: 4] <= s_nib;
                    carry_reg                  <= c[4];
                    if (last_nib) begin
                        cout_reg <= c[4];
                        ovf_reg  <= c[3] ^ c[4];
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_sum  = sum_reg;
    assign rsp_cout = cout_reg;
    assign rsp_ovf  = ovf_reg;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - scoreboard bench for nibble_serial_add_ctrl
module tb_nibble_serial_add_ctrl;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [WIDTH-1:0] req_a = '0;
    logic [WIDTH-1:0] req_b = '0;
    logic             req_sub = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic             rsp_ovf;

    rsp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic rsp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
        rsp_t             r;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    // Called at a negedge while the DUT is idle; returns at the negedge after the handshake.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                        input int stall, input bit scramble);
        int               lat;
        rsp_t             e;
        logic [WIDTH-1:0] held_sum;
        logic             held_cout, held_ovf;
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_a = a; req_b = b; req_sub = sub; req_valid = 1'b1;
        exp_q.push_back(model(a, b, sub));
        @(negedge clk);
        if (stall == 0) req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            check("req_ready_busy", {31'b0, req_ready}, 32'd0);
            if (scramble) begin
                req_a = WIDTH'($urandom);
                req_b = WIDTH'($urandom);
                req_sub = 1'($urandom);
                rsp_ready = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        check("latency", lat, NIB);
        held_sum = rsp_sum; held_cout = rsp_cout; held_ovf = rsp_ovf;
        for (int i = 0; i < stall; i++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            check("stall_valid", {31'b0, rsp_valid}, 32'd1);
            check("stall_ready", {31'b0, req_ready}, 32'd0);
            check("stall_sum", {16'b0, rsp_sum}, {16'b0, held_sum});
            check("stall_flags", {30'b0, rsp_cout, rsp_ovf}, {30'b0, held_cout, held_ovf});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        e = exp_q.pop_front();
        check("sum", {16'b0, rsp_sum}, {16'b0, e.sum});
        check("cout", {31'b0, rsp_cout}, {31'b0, e.cout});
        check("ovf", {31'b0, rsp_ovf}, {31'b0, e.ovf});
        @(negedge clk);
        rsp_ready = 1'b0;
        check("valid_after_hs", {31'b0, rsp_valid}, 32'd0);
        check("sum_hold", {16'b0, rsp_sum}, {16'b0, e.sum});
    endtask

    initial begin
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_outs", {14'b0, rsp_sum, rsp_cout, rsp_ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        send(16'h0005, 16'h0007, 1'b1, 0, 1'b0);
        send(16'h8000, 16'h0001, 1'b1, 0, 1'b0);
        send(16'hA5C3, 16'h1E2D, 1'b0, 3, 1'b0);
        send(16'h3C4B, 16'h9F01, 1'b1, 0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), i % 3, 1'b1);
        end

        req_a = 16'hAAAA; req_b = 16'h1111; req_sub = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        check("abort_valid", {31'b0, rsp_valid}, 32'd0);
        check("abort_outs", {14'b0, rsp_sum, rsp_cout, rsp_ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        send(16'h1234, 16'h1111, 1'b0, 0, 1'b0);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
